vote_result_tx: RTL and testbench

VOTE_RESULT_TX -- requirements
Module: vote_result_tx

---
 rtl/vote_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 46 ++++
 rtl/vote_result_tx.sv | 59 +++++
 tb/tb_vote_result_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// vote_pkg: shared constants, FSM states and result helpers for the vote report transmitter
package vote_pkg;
  localparam logic [7:0] HEADER = 8'hA5;
  localparam int FRAME_BYTES = 5;
  localparam int STATUS_WIN_LSB = 0;
  localparam int STATUS_TIE_BIT = 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  // Returns {tie, winner}; any shared maximum (including all-zero) is a tie.
  function automatic logic [2:0] resolve(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return (a > b && a > c) ? 3'b001 :
           (b > a && b > c) ? 3'b010 :
           (c > a && c > b) ? 3'b011 : 3'b100;
  endfunction
  function automatic logic [7:0] status_byte(input logic tie, input logic [1:0] winner);
    logic [7:0] s;
    s = '0;
    s[STATUS_TIE_BIT] = tie;
    s[STATUS_WIN_LSB +: 2] = winner;
    return s;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; ready also rises in the last stop-bit cycle so bytes chain gap-free
module uart_tx_byte
  import vote_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       ready
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t state, state_n;
  logic [15:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic baud_end;
  assign baud_end = baud == LAST;
  assign ready = state == IDLE || (state == STOP && baud_end);
  assign tx = state == START ? 1'b0 : state == DATA ? sh[bit_idx] : 1'b1;
  always_comb begin
    state_n = state;
    case (state)
      START: state_n = baud_end ? DATA : START;
      DATA: state_n = (baud_end && bit_idx == 3'd7) ? STOP : DATA;
      STOP: state_n = baud_end ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    if (ready && start) state_n = START;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      baud <= (state == IDLE || baud_end) ? 16'd0 : baud + 16'd1;
      bit_idx <= (state == DATA && baud_end) ? bit_idx + 3'd1 : bit_idx;
      sh <= (ready && start) ? byte_in : sh;
    end
  end
endmodule

// File: rtl/vote_result_tx.sv
// vote_result_tx: snapshots three tallies on a request edge, resolves the winner and sends a 5-byte UART report
module vote_result_tx
  import vote_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count1,
  input  logic [7:0] count2,
  input  logic [7:0] count3,
  input  logic       report_req,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       tie
);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
  logic prev, ready, accept, next_byte, last_byte;
  logic [2:0] byte_idx, k;
  logic [7:0] s1, s2, s3, byte_in;
  assign accept = report_req && !prev && !busy;
  assign next_byte = busy && ready && byte_idx != LAST_IDX;
  assign last_byte = busy && ready && byte_idx == LAST_IDX;
  assign k = byte_idx + 3'd1;
  assign byte_in = accept ? HEADER : k == 3'd1 ? s1 : k == 3'd2 ? s2 : k == 3'd3 ? s3 : status_byte(tie, winner);
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk(clk),
    .rst(rst),
    .start(accept || next_byte),
    .byte_in(byte_in),
    .tx(tx),
    .ready(ready)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      byte_idx <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      {tie, winner} <= '0;
    end else begin
      prev <= report_req;
      done <= last_byte;
      busy <= accept || (busy && !last_byte);
      byte_idx <= (accept || last_byte) ? 3'd0 : next_byte ? k : byte_idx;
      if (accept) begin
        s1 <= count1;
        s2 <= count2;
        s3 <= count3;
        {tie, winner} <= resolve(count1, count2, count3);
      end
    end
  end
endmodule

// File: tb/tb_vote_result_tx.sv
// tb_vote_result_tx: table-driven and randomized frame checks against a waveform-level reference model
module tb_vote_result_tx;
  localparam int C = 4;
  localparam int FB = 50 * C;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] count1 = '0, count2 = '0, count3 = '0;
  logic report_req = 1'b0;
  logic tx, busy, done, tie;
  logic [1:0] winner;
  int errors = 0, checks = 0;
  int done_cnt = 0, starts = 0;
  logic busy_q = 1'b0;

  vote_result_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .count1(count1), .count2(count2), .count3(count3),
    .report_req(report_req), .tx(tx), .busy(busy), .done(done), .winner(winner), .tie(tie)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    busy_q <= busy;
    if (busy && !busy_q) starts <= starts + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: winner is the unique holder of the maximum tally, else tie.
  function automatic logic [2:0] model(input int a, input int b, input int c);
    int m, n;
    m = a > b ? a : b;
    m = m > c ? m : c;
    n = int'(a == m) + int'(b == m) + int'(c == m);
    if (n > 1) return 3'b100;
    return {1'b0, a == m ? 2'd1 : b == m ? 2'd2 : 2'd3};
  endfunction

  // Caller must be at a negedge. mode 1: disturb inputs mid-frame; mode 2: keep report_req high.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [1:0] ew, input logic et, input int mode, input string tag);
    logic [7:0] exp [5];
    logic cap [FB];
    logic [7:0] d;
    int bad, wbad, by, ph, eb;
    bad = 0;
    wbad = 0;
    exp = '{8'hA5, a, b, c, {5'b0, et, ew}};
    count1 = a;
    count2 = b;
    count3 = c;
    report_req = 1'b1;
    @(posedge clk);
    for (int i = 0; i < FB; i++) begin
      @(negedge clk);
      cap[i] = tx;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (i == 0) begin
        chk({tag, "_winner"}, int'(winner), int'(ew));
        chk({tag, "_tie"}, int'(tie), int'(et));
        if (mode != 2) report_req = 1'b0;
      end
      if (mode == 1 && i == 50) begin
        count1 = ~a;
        count3 = c + 8'd1;
        report_req = 1'b1;
      end
      if (mode == 1 && i == 52) report_req = 1'b0;
    end
    chk({tag, "_busy_during"}, bad, 0);
    for (int i = 0; i < FB; i++) begin
      by = i / (10 * C);
      ph = (i % (10 * C)) / C;
      eb = ph == 0 ? 0 : ph == 9 ? 1 : int'(exp[by][ph-1]);
      if (int'(cap[i]) != eb) wbad++;
    end
    chk({tag, "_wave"}, wbad, 0);
    for (int j = 0; j < 5; j++) begin
      for (int q = 0; q < 8; q++) d[q] = cap[j * 10 * C + (q + 1) * C + C / 2];
      chk($sformatf("%s_byte%0d", tag, j), int'(d), int'(exp[j]));
    end
    @(negedge clk);
    chk({tag, "_end_busy"}, int'(busy), 0);
    chk({tag, "_end_done"}, int'(done), 1);
    chk({tag, "_end_tx"}, int'(tx), 1);
    chk({tag, "_hold_winner"}, int'({tie, winner}), int'({et, ew}));
  endtask

  typedef struct {
    logic [7:0] a, b, c;
    logic [1:0] w;
    logic t;
    int mode;
  } vec_t;

  initial begin
    vec_t tbl [5];
    logic [7:0] ra, rb, rc;
    logic [2:0] m;
    int s0, d0, idle_bad, k;
    tbl = '{'{8'd3, 8'd1, 8'd2, 2'd1, 1'b0, 0},
            '{8'd5, 8'd5, 8'd2, 2'd0, 1'b1, 0},
            '{8'd0, 8'd0, 8'd7, 2'd3, 1'b0, 0},
            '{8'd0, 8'd0, 8'd0, 2'd0, 1'b1, 0},
            '{8'd9, 8'd200, 8'd199, 2'd2, 1'b0, 1}};
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'({tie, winner}), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      s0 = starts;
      frame(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].w, tbl[i].t, tbl[i].mode, $sformatf("vec%0d", i));
      repeat (30) @(negedge clk);
      chk($sformatf("vec%0d_one_frame", i), starts - s0, 1);
      chk($sformatf("vec%0d_done_low", i), int'(done), 0);
    end
    frame(8'd1, 8'd2, 8'd3, 2'd3, 1'b0, 0, "chainA");
    frame(8'd7, 8'd6, 8'd5, 2'd1, 1'b0, 0, "chainB");
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = (i % 3 == 0) ? ra : 8'($urandom);
      rc = (i % 3 == 1) ? ra : 8'($urandom);
      m = model(ra, rb, rc);
      frame(ra, rb, rc, m[1:0], m[2], 0, $sformatf("rnd%0d", i));
      @(negedge clk);
    end
    s0 = starts;
    d0 = done_cnt;
    frame(8'd4, 8'd8, 8'd2, 2'd2, 1'b0, 2, "hold");
    repeat (1000 - FB) @(negedge clk);
    report_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_frames", starts - s0, 1);
    chk("hold_dones", done_cnt - d0, 1);
    count1 = 8'd10;
    report_req = 1'b1;
    @(posedge clk);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    report_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    idle_bad = 0;
    repeat (FB) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    chk("abort_idle", idle_bad, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    rst = 1'b1;
    report_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_busy", int'(busy), 1);
    chk("rel_tx", int'(tx), 0);
    k = 0;
    for (int i = 1; i <= FB + 20 && k == 0; i++) begin
      @(negedge clk);
      if (done) k = i;
    end
    chk("rel_done_cycle", k, FB);
    report_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
